// File: rtl/apb_ram_pkg.sv
// Shared definitions for the APB RAM scheduler slice.
//   state_t      : scheduler FSM states
//   BANK_DEPTH   : words per RAM bank
//   BANK_SEL_*   : address bits selecting the bank
package apb_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned BANK_DEPTH  = 64;
    localparam int unsigned BANK_SEL_LO = 6;
    localparam int unsigned BANK_SEL_HI = 8;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   enable   : arbitration allowed this cycle (grant forced to 0 otherwise)
//   valid    : request bits, bit i = requester i
//   grant    : one-hot winner, combinational
module apb_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // Index of the requester granted most recently; starts at 1 so that
    // requester 0 wins the first tie.
    logic last_grant;

    always_comb begin
        grant = '0;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/apb_ram_scheduler.sv
// Schedules requests from two requesters onto a single APB master port
// in front of NUM_BANKS banks of 64-word RAM.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/write     : per-requester request strobe and direction
//   req_addr/wdata      : per-requester address and write data (packed)
//   req_ready           : one-hot acceptance pulse
//   rsp_valid           : one-hot completion pulse to the owning requester
//   rsp_rdata/rsp_err   : completion data and error flag
//   paddr..pready       : APB master towards the RAM banks
module apb_ram_scheduler #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 5,
    parameter int TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   paddr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready
);
    import apb_ram_pkg::*;

    localparam int unsigned ADDR_LIMIT = NUM_BANKS * BANK_DEPTH;
    localparam int          TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              state, state_nxt;
    logic [1:0]          grant;
    logic                arb_en;
    logic [1:0]          owner;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [TO_W-1:0]     to_cnt;
    logic                timeout_hit;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                addr_bad;

    // Gating with rst keeps req_ready low while reset is held, even
    // though the state register already reads IDLE.
    assign arb_en = (state == ST_IDLE) && !rst;

    apb_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (arb_en),
        .valid  (req_valid),
        .grant  (grant)
    );

    always_comb begin
        if (grant[1]) begin
            sel_write = req_write[1];
            sel_addr  = req_addr[ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[DATA_W +: DATA_W];
        end else begin
            sel_write = req_write[0];
            sel_addr  = req_addr[0 +: ADDR_W];
            sel_wdata = req_wdata[0 +: DATA_W];
        end
    end

    // Out of range if beyond the populated banks, or if any bit above the
    // bank-select field is set.
    assign addr_bad = (32'(sel_addr) >= ADDR_LIMIT) ||
                      ((sel_addr >> (BANK_SEL_HI + 1)) != '0);

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));

    assign paddr  = lat_addr;
    assign pwrite = lat_write;
    assign pwdata = lat_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    state_nxt = addr_bad ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = owner;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            to_cnt    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner     <= grant;
                        lat_write <= sel_write;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        to_cnt    <= '0;
                        rsp_err   <= addr_bad;
                        rsp_rdata <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (pready) begin
                        rsp_rdata <= lat_write ? '0 : prdata;
                        rsp_err   <= 1'b0;
                        to_cnt    <= '0;
                    end else if (timeout_hit) begin
                        rsp_err   <= 1'b1;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt    <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_ram_scheduler.sv
// Self-checking bench for apb_ram_scheduler: reset values, round-robin
// sequence, a table of single transfers (including address errors and
// pready timeout), reset during ACCESS, and randomized traffic checked
// against a transaction-level model.
module tb_apb_ram_scheduler;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int NUM_BANKS = 5;
    localparam int TIMEOUT   = 15;
    localparam int MEM_WORDS = NUM_BANKS * 64;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          req_valid = '0;
    logic [1:0]          req_write = '0;
    logic [2*ADDR_W-1:0] req_addr  = '0;
    logic [2*DATA_W-1:0] req_wdata = '0;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W-1:0]   prdata;
    logic                pready = 1'b1;

    apb_ram_scheduler #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_BANKS (NUM_BANKS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- APB RAM slave ----------------
    // mode 0: always ready, 1: random 0..4 wait states, 2: never ready
    int mode = 0;
    int wait_left = 0;
    logic [31:0] mem [MEM_WORDS] = '{default: '0};

    always @(negedge clk) begin
        if (mode == 0) begin
            pready = 1'b1;
        end else if (mode == 2) begin
            pready = 1'b0;
        end else if (psel && !penable) begin
            wait_left = $urandom_range(0, 4);
            pready = 1'b0;
        end else if (psel && penable) begin
            pready = (wait_left == 0);
            if (wait_left != 0) wait_left = wait_left - 1;
        end else begin
            pready = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (psel && penable && pready && pwrite && (int'(paddr) < MEM_WORDS))
            mem[int'(paddr)] <= pwdata;
    end

    always_comb begin
        prdata = '0;
        if (int'(paddr) < MEM_WORDS) prdata = mem[int'(paddr)];
    end

    // ---------------- helpers ----------------
    logic [31:0] ref_mem [MEM_WORDS];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic run_txn(input int id, input logic wr, input logic [15:0] addr,
                           input logic [31:0] wd, output logic accepted,
                           output logic [1:0] got_owner, output logic [31:0] got_rdata,
                           output logic got_err, output int lat, output int n_psel,
                           output int n_pen, output int bus_bad);
        int t0;
        accepted = 1'b0; got_owner = '0; got_rdata = '0; got_err = 1'b0;
        lat = -1; n_psel = 0; n_pen = 0; bus_bad = 0;
        @(negedge clk);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_write[id] = wr;
        req_addr[id*ADDR_W +: ADDR_W] = addr;
        req_wdata[id*DATA_W +: DATA_W] = wd;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready[id]) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        t0 = cyc;
        @(negedge clk);
        req_valid = '0;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (psel) begin
                n_psel++;
                if (penable) n_pen++;
                if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wd)) bus_bad++;
            end
            if (rsp_valid != '0) begin
                got_owner = rsp_valid;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                lat       = cyc - t0;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    typedef struct {
        int          id;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          pmode;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_psel;
        int          exp_pen;
    } vec_t;

    vec_t vecs[11];

    // random-phase state
    logic [1:0]  taken;
    logic        r_wr   [2];
    logic [15:0] r_addr [2];
    logic [31:0] r_wd   [2];
    int          model_last;
    logic        have_exp;
    logic [1:0]  exp_owner;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_t;
    int          n_rsp;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        logic        acc;
        logic [1:0]  own;
        logic [31:0] rd;
        logic        er;
        int          lat, nps, npe, bb;
        logic [1:0]  exp_own;
        int          g;
        int          gt [4];
        logic [1:0]  gw [4];
        int          viol;
        int          seen;

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;

        // ---------- reset values (requests driven during reset) ----------
        req_valid = 2'b11;
        req_addr  = {16'h0011, 16'h0022};
        req_wdata = {32'hAAAA5555, 32'h5555AAAA};
        req_write = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        req_valid = '0;
        req_write = '0;
        @(negedge clk);
        rst = 1'b0;

        // ---------- round robin, both requesters always valid ----------
        mode = 0;
        @(negedge clk);
        req_addr  = {16'h0002, 16'h0001};
        req_write = 2'b00;
        req_valid = 2'b11;
        #1;
        g = 0; viol = 0;
        for (int i = 0; i < 4; i++) begin gt[i] = 0; gw[i] = '0; end
        for (int k = 0; k < 40; k++) begin
            if (req_ready != '0 && (psel || rsp_valid != '0)) viol++;
            if (req_ready != '0) begin
                gw[g] = req_ready;
                gt[g] = cyc;
                g++;
            end
            if (g == 4) break;
            @(negedge clk); #1;
        end
        chk("rr_grant0", gw[0], 2'b01);
        chk("rr_grant1", gw[1], 2'b10);
        chk("rr_grant2", gw[2], 2'b01);
        chk("rr_grant3", gw[3], 2'b10);
        chk("rr_spacing01", gt[1] - gt[0], 4);
        chk("rr_spacing23", gt[3] - gt[2], 4);
        chk("rr_no_grant_busy", viol, 0);
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);

        // ---------- table of single transfers ----------
        vecs[0]  = '{0, 1'b1, 16'h0005, 32'hDEADBEEF, 0, 32'h0,        1'b0, 3,  2,  1};
        vecs[1]  = '{1, 1'b1, 16'h0085, 32'h12345678, 0, 32'h0,        1'b0, 3,  2,  1};
        vecs[2]  = '{1, 1'b0, 16'h0085, 32'h0,        0, 32'h12345678, 1'b0, 3,  2,  1};
        vecs[3]  = '{0, 1'b0, 16'h0005, 32'h0,        0, 32'hDEADBEEF, 1'b0, 3,  2,  1};
        vecs[4]  = '{0, 1'b0, 16'h0140, 32'h0,        0, 32'h0,        1'b1, 1,  0,  0};
        vecs[5]  = '{1, 1'b1, 16'h013F, 32'hCAFEF00D, 0, 32'h0,        1'b0, 3,  2,  1};
        vecs[6]  = '{0, 1'b0, 16'h013F, 32'h0,        0, 32'hCAFEF00D, 1'b0, 3,  2,  1};
        vecs[7]  = '{1, 1'b0, 16'hFFFF, 32'h0,        0, 32'h0,        1'b1, 1,  0,  0};
        vecs[8]  = '{0, 1'b1, 16'h0140, 32'h55AA55AA, 0, 32'h0,        1'b1, 1,  0,  0};
        vecs[9]  = '{1, 1'b0, 16'h0100, 32'h0,        2, 32'h0,        1'b1, 17, 16, 15};
        vecs[10] = '{1, 1'b0, 16'h0005, 32'h0,        0, 32'hDEADBEEF, 1'b0, 3,  2,  1};

        for (int i = 0; i < 11; i++) begin
            mode = vecs[i].pmode;
            run_txn(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    acc, own, rd, er, lat, nps, npe, bb);
            exp_own = '0;
            exp_own[vecs[i].id] = 1'b1;
            chk($sformatf("vec%0d_accept", i), acc, 1);
            chk($sformatf("vec%0d_owner", i), own, exp_own);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_psel_cycles", i), nps, vecs[i].exp_psel);
            chk($sformatf("vec%0d_penable_cycles", i), npe, vecs[i].exp_pen);
            chk($sformatf("vec%0d_bus_stable", i), bb, 0);
            if (vecs[i].wr && !vecs[i].exp_err) ref_mem[int'(vecs[i].addr)] = vecs[i].wdata;
        end
        mode = 0;
        @(negedge clk);

        // ---------- reset asserted during ACCESS ----------
        mode = 2;
        @(negedge clk);
        req_write[1] = 1'b0;
        req_addr[ADDR_W +: ADDR_W] = 16'h0010;
        req_valid = 2'b10;
        #1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (psel && penable) begin seen = 1; break; end
            @(negedge clk);
            req_valid = '0;
            #1;
        end
        req_valid = '0;
        chk("mid_rst_reached_access", seen, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_paddr", paddr, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk); #1;
            if (rsp_valid != '0 || psel) seen++;
        end
        chk("mid_rst_no_response", seen, 0);

        // ---------- randomized traffic vs. transaction model ----------
        mode = 1;
        model_last = 1;
        have_exp = 1'b0;
        taken = '0;
        n_rsp = 0;
        exp_owner = '0; exp_rdata = '0; exp_err = 1'b0; exp_t = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (taken[i]) begin req_valid[i] = 1'b0; taken[i] = 1'b0; end
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    r_wr[i] = $urandom_range(0, 1) == 1;
                    case ($urandom_range(0, 9))
                        0:       r_addr[i] = 16'($urandom());
                        1, 2:    r_addr[i] = 16'($urandom_range(300, 339));
                        default: r_addr[i] = 16'($urandom_range(0, 31));
                    endcase
                    r_wd[i] = $urandom();
                    req_write[i] = r_wr[i];
                    req_addr[i*ADDR_W +: ADDR_W] = r_addr[i];
                    req_wdata[i*DATA_W +: DATA_W] = r_wd[i];
                    req_valid[i] = 1'b1;
                end
            end
            #1;
            if (rsp_valid != '0) begin
                chk("rand_rsp_expected", have_exp, 1);
                chk("rand_rsp_owner", rsp_valid, exp_owner);
                chk("rand_rsp_rdata", rsp_rdata, exp_rdata);
                chk("rand_rsp_err", rsp_err, exp_err);
                have_exp = 1'b0;
                n_rsp++;
            end else if (have_exp && (cyc - exp_t) > 25) begin
                chk("rand_rsp_timely", 0, 1);
                have_exp = 1'b0;
            end
            if (req_ready != '0) begin
                int w;
                logic [1:0] er_exp;
                int a;
                if (req_valid == 2'b11) w = (model_last == 1) ? 0 : 1;
                else w = req_valid[1] ? 1 : 0;
                er_exp = '0;
                er_exp[w] = 1'b1;
                chk("rand_grant", req_ready, er_exp);
                chk("rand_grant_when_idle", have_exp, 0);
                model_last = w;
                a = int'(r_addr[w]);
                exp_owner = er_exp;
                exp_err = (a >= MEM_WORDS);
                exp_rdata = (!r_wr[w] && !exp_err) ? ref_mem[a] : 32'h0;
                if (r_wr[w] && !exp_err) ref_mem[a] = r_wd[w];
                have_exp = 1'b1;
                exp_t = cyc;
                taken[w] = 1'b1;
            end
        end
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < 30 && have_exp; k++) begin
            #1;
            if (rsp_valid != '0) begin
                chk("rand_drain_owner", rsp_valid, exp_owner);
                chk("rand_drain_rdata", rsp_rdata, exp_rdata);
                chk("rand_drain_err", rsp_err, exp_err);
                have_exp = 1'b0;
                n_rsp++;
            end
            @(negedge clk);
        end
        chk("rand_drain_complete", have_exp, 0);
        chk("rand_activity", (n_rsp > 200), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
